// File: rtl/csel_subtractor_seq_if.sv
// Handshake and data bundle for the chunked carry-select subtractor.
interface csel_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/csel_subtractor_seq.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, CHUNK bits per clock, LSB chunk first.
// Each chunk computes both borrow-in cases in parallel; the registered borrow picks one.
module csel_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    csel_subtractor_seq_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_work;
    logic [WIDTH-1:0] b_work;
    logic [WIDTH-1:0] diff_work;
    logic             borrow;
    logic [IDXW-1:0]  idx;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK:0]   d0;
    logic [CHUNK:0]   d1;
    logic [CHUNK:0]   sel;
    logic [WIDTH-1:0] diff_next;
    logic             last;

    // Operands shift right so the current chunk is always at the bottom; result
    // chunks enter from the top and land in their own slice after NCH steps.
    always_comb begin
        d0        = {1'b0, a_work[CHUNK-1:0]} - {1'b0, b_work[CHUNK-1:0]};
        d1        = {1'b0, a_work[CHUNK-1:0]} - {1'b0, b_work[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, 1'b1};
        sel       = borrow ? d1 : d0;
        diff_next = (diff_work >> CHUNK) | (WIDTH'(sel[CHUNK-1:0]) << (WIDTH - CHUNK));
        last      = (idx == IDXW'(NCH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_work      <= '0;
            b_work      <= '0;
            diff_work   <= '0;
            borrow      <= 1'b0;
            idx         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_work     <= bus.a;
                        b_work     <= bus.b;
                        borrow     <= bus.bin;
                        diff_work  <= '0;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_work    <= a_work >> CHUNK;
                    b_work    <= b_work >> CHUNK;
                    diff_work <= diff_next;
                    borrow    <= sel[CHUNK];
                    idx       <= idx + IDXW'(1);
                    if (last) begin
                        diff_q      <= diff_next;
                        bout_q      <= sel[CHUNK];
                        zero_q      <= (diff_next == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_csel_subtractor_seq.sv
// Bench for csel_subtractor_seq: directed cases plus randomized traffic against an
// arithmetic reference model with per-cycle output comparison.
module tb_csel_subtractor_seq;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csel_subtractor_seq_if #(.WIDTH(WIDTH)) bus ();

    csel_subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_results    = 0;

    res_t   sb_q[$];
    bit     m_active    = 1'b0;
    bit     m_in_ready  = 1'b1;
    bit     m_out_valid = 1'b0;
    res_t   m_out       = '{diff: '0, bout: 1'b0, zero: 1'b1};
    longint edge_n      = 0;
    longint m_due       = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic bin);
        logic [WIDTH:0] full;
        res_t           r;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        r.diff = full[WIDTH-1:0];
        r.bout = full[WIDTH];
        r.zero = (full[WIDTH-1:0] == '0);
        return r;
    endfunction

    // Reference model: checks this cycle's outputs, then predicts the effect of the coming edge.
    always @(negedge clk) begin
        res_t e;
        if (m_active) begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_in_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
            chk("diff",      32'(bus.diff),      32'(m_out.diff));
            chk("bout",      32'(bus.bout),      32'(m_out.bout));
            chk("zero",      32'(bus.zero),      32'(m_out.zero));
            if (m_out_valid && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL order: result delivered with no accepted op, got 0x%0h required none", bus.diff);
                end else begin
                    e = sb_q.pop_front();
                    chk("order_diff", 32'(bus.diff), 32'(e.diff));
                    n_results++;
                end
            end
        end
        edge_n++;
        if (!rst_n) begin
            m_active    = 1'b1;
            m_in_ready  = 1'b1;
            m_out_valid = 1'b0;
            m_out       = '{diff: '0, bout: 1'b0, zero: 1'b1};
            m_due       = -1;
            sb_q.delete();
        end else if (m_active) begin
            if (m_in_ready && bus.in_valid) begin
                sb_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
                m_in_ready = 1'b0;
                m_due      = edge_n + NCH;
            end else if (m_out_valid && bus.out_ready) begin
                m_out_valid = 1'b0;
                m_in_ready  = 1'b1;
            end
            if (edge_n == m_due && sb_q.size() != 0) begin
                m_out_valid = 1'b1;
                m_out       = sb_q[0];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] ediff, input logic ebout,
                               input logic ezero, input logic ein_ready, input logic eout_valid);
        chk({name, "_diff"},      32'(bus.diff),      32'(ediff));
        chk({name, "_bout"},      32'(bus.bout),      32'(ebout));
        chk({name, "_zero"},      32'(bus.zero),      32'(ezero));
        chk({name, "_in_ready"},  32'(bus.in_ready),  32'(ein_ready));
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'(eout_valid));
    endtask

    // Presents operands until the DUT accepts them; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic waitOutput(output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
    endtask

    task automatic handshakeOut();
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, input logic [WIDTH-1:0] ediff, input logic ebout,
                         input logic ezero);
        int lat;
        applyStimulus(a, b, bin);
        waitOutput(lat);
        chk({name, "_latency"}, 32'(lat), 32'(NCH));
        checkOutput(name, ediff, ebout, ezero, 1'b0, 1'b1);
        handshakeOut();
    endtask

    initial begin
        #5_000_000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res_t            r;
        int              lat;
        int              r0;
        bit              rnd_done;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        rnd_done      = 1'b0;

        // Hand-computed values that pin the reference model.
        r = ref_sub(16'h1234, 16'h0234, 1'b0);
        chk("model_pin1_diff", 32'(r.diff), 32'h1000);
        r = ref_sub(16'h0000, 16'h0001, 1'b0);
        chk("model_pin2_diff", 32'(r.diff), 32'hFFFF);
        chk("model_pin2_bout", 32'(r.bout), 32'h1);
        r = ref_sub(16'h8000, 16'h7FFF, 1'b1);
        chk("model_pin3_zero", 32'(r.zero), 32'h1);

        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

        runOp("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        runOp("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        runOp("t3", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Back-pressure in DONE with a competing request that must be ignored.
        applyStimulus(16'h00FF, 16'h000F, 1'b0);
        waitOutput(lat);
        chk("t4_latency", 32'(lat), 32'(NCH));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.b        = 16'h1111;
        bus.bin      = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_hold", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("t4_idle", 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        waitOutput(lat);
        chk("t4_new_latency", 32'(lat), 32'(NCH));
        checkOutput("t4_new", 16'h9998, 1'b0, 1'b0, 1'b0, 1'b1);
        handshakeOut();

        // Reset after chunk 2 of an op aborts it.
        applyStimulus(16'h0F0F, 16'h1234, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_abort", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) begin
            @(negedge clk);
            chk("t5_no_result", 32'(bus.out_valid), 32'h0);
        end

        // Randomized traffic with gaps on both sides of the handshake.
        r0 = n_results;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    ra = WIDTH'($urandom);
                    rb = WIDTH'($urandom);
                    if ($urandom_range(0, 7) == 0) ra = '0;
                    if ($urandom_range(0, 7) == 0) rb = '1;
                    applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < 500 && (n_results - r0) < 1000; i++) @(negedge clk);
                chk("random_result_count", 32'(n_results - r0), 32'd1000);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                bus.out_ready = 1'b0;
            end
        join

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
